// File: rtl/reg_write_arbiter.sv
// Two-requester register-file writeback arbiter (ALU vs load).
// One pending slot per requester, one registered write per cycle.
module reg_write_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        aluValid,
  output logic        aluReady,
  input  logic [4:0]  aluRd,
  input  logic [31:0] aluData,
  input  logic        memValid,
  output logic        memReady,
  input  logic [4:0]  memRd,
  input  logic [31:0] memData,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic [31:0] busyMask
);

  localparam bit FixedPri = (PRIORITY_MODE != 0);

  logic        aluV;
  logic [4:0]  aluRdQ;
  logic [31:0] aluDataQ;
  logic        memV;
  logic [4:0]  memRdQ;
  logic [31:0] memDataQ;
  logic        lastMem;
  logic        grantAlu;
  logic        grantMem;
  logic        aluAcc;
  logic        memAcc;

  // Same-rd ties go to memory so the younger ALU value lands last.
  always_comb begin
    grantAlu = 1'b0;
    grantMem = 1'b0;
    unique case (1'b1)
      (aluV && memV): begin
        if ((aluRdQ == memRdQ) || FixedPri || !lastMem)
          grantMem = 1'b1;
        else
          grantAlu = 1'b1;
      end
      (aluV && !memV): grantAlu = 1'b1;
      (!aluV && memV): grantMem = 1'b1;
      default: ;
    endcase
  end

  assign aluReady = reset && (!aluV || grantAlu);
  assign memReady = reset && (!memV || grantMem);
  assign aluAcc   = aluValid && aluReady;
  assign memAcc   = memValid && memReady;

  always_comb begin
    busyMask = 32'd0;
    if (reset && aluV)
      busyMask[aluRdQ] = 1'b1;
    if (reset && memV)
      busyMask[memRdQ] = 1'b1;
    busyMask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      aluV      <= 1'b0;
      aluRdQ    <= 5'd0;
      aluDataQ  <= 32'd0;
      memV      <= 1'b0;
      memRdQ    <= 5'd0;
      memDataQ  <= 32'd0;
      lastMem   <= 1'b1;
      regWrite  <= 1'b0;
      writeReg  <= 5'd0;
      writeData <= 32'd0;
    end else begin
      if (aluAcc && (aluRd != 5'd0)) begin
        aluV     <= 1'b1;
        aluRdQ   <= aluRd;
        aluDataQ <= aluData;
      end else if (grantAlu) begin
        aluV <= 1'b0;
      end
      if (memAcc && (memRd != 5'd0)) begin
        memV     <= 1'b1;
        memRdQ   <= memRd;
        memDataQ <= memData;
      end else if (grantMem) begin
        memV <= 1'b0;
      end
      regWrite <= grantAlu || grantMem;
      if (grantMem) begin
        writeReg  <= memRdQ;
        writeData <= memDataQ;
        lastMem   <= 1'b1;
      end else if (grantAlu) begin
        writeReg  <= aluRdQ;
        writeData <= aluDataQ;
        lastMem   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter.
// dut0 runs round-robin, dut1 fixed priority; both see the same stimulus.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        memValid;
  logic [4:0]  memRd;
  logic [31:0] memData;

  logic        aluReady0, memReady0, regWrite0;
  logic [4:0]  writeReg0;
  logic [31:0] writeData0, busyMask0;
  logic        aluReady1, memReady1, regWrite1;
  logic [4:0]  writeReg1;
  logic [31:0] writeData1, busyMask1;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.PRIORITY_MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluReady(aluReady0),
    .aluRd(aluRd), .aluData(aluData),
    .memValid(memValid), .memReady(memReady0),
    .memRd(memRd), .memData(memData),
    .regWrite(regWrite0), .writeReg(writeReg0),
    .writeData(writeData0), .busyMask(busyMask0)
  );

  reg_write_arbiter #(.PRIORITY_MODE(1)) dut1 (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluReady(aluReady1),
    .aluRd(aluRd), .aluData(aluData),
    .memValid(memValid), .memReady(memReady1),
    .memRd(memRd), .memData(memData),
    .regWrite(regWrite1), .writeReg(writeReg1),
    .writeData(writeData1), .busyMask(busyMask1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nVec++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aluValid = 1'b0;
    memValid = 1'b0;
    aluRd    = 5'd0;
    memRd    = 5'd0;
    aluData  = 32'd0;
    memData  = 32'd0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1;
    chk("rst aluReady", 32'(aluReady0), 32'd0);
    chk("rst memReady", 32'(memReady0), 32'd0);
    chk("rst busyMask", busyMask0, 32'd0);
    tick();
    tick();
    chk("rst regWrite", 32'(regWrite0), 32'd0);
    chk("rst writeReg", 32'(writeReg0), 32'd0);
    chk("rst writeData", writeData0, 32'd0);
    reset = 1'b1;
    #1;
    chk("post-rst aluReady", 32'(aluReady0), 32'd1);
    chk("post-rst memReady", 32'(memReady0), 32'd1);

    // single ALU write
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hAA;
    tick();
    idle();
    #1;
    chk("single busy", busyMask0, 32'h20);
    chk("single no early wr", 32'(regWrite0), 32'd0);
    tick();
    chk("single regWrite", 32'(regWrite0), 32'd1);
    chk("single writeReg", 32'(writeReg0), 32'd5);
    chk("single writeData", writeData0, 32'hAA);
    chk("single busy clr", busyMask0, 32'd0);
    tick();
    chk("single wr drop", 32'(regWrite0), 32'd0);
    chk("single reg hold", 32'(writeReg0), 32'd5);
    chk("single data hold", writeData0, 32'hAA);

    // tie after reset: ALU first in round-robin
    reset = 1'b0;
    tick();
    reset = 1'b1;
    aluValid = 1'b1; aluRd = 5'd3; aluData = 32'h11;
    memValid = 1'b1; memRd = 5'd4; memData = 32'h22;
    tick();
    idle();
    #1;
    chk("tie memReady lose", 32'(memReady0), 32'd0);
    chk("tie aluReady win", 32'(aluReady0), 32'd1);
    chk("tie busy", busyMask0, 32'h18);
    tick();
    chk("tie wr1 en", 32'(regWrite0), 32'd1);
    chk("tie wr1 reg", 32'(writeReg0), 32'd3);
    chk("tie wr1 data", writeData0, 32'h11);
    chk("tie memReady win", 32'(memReady0), 32'd1);
    chk("fixed tie wr1 reg", 32'(writeReg1), 32'd4);
    tick();
    chk("tie wr2 en", 32'(regWrite0), 32'd1);
    chk("tie wr2 reg", 32'(writeReg0), 32'd4);
    chk("tie wr2 data", writeData0, 32'h22);
    tick();
    chk("tie done", 32'(regWrite0), 32'd0);

    // x0 filter
    memValid = 1'b1; memRd = 5'd0; memData = 32'hFFFF_FFFF;
    #1;
    chk("x0 memReady", 32'(memReady0), 32'd1);
    tick();
    idle();
    #1;
    chk("x0 busy", busyMask0, 32'd0);
    tick();
    chk("x0 no write", 32'(regWrite0), 32'd0);

    // same-rd collision: mem first, ALU last
    aluValid = 1'b1; aluRd = 5'd7; aluData = 32'h1;
    memValid = 1'b1; memRd = 5'd7; memData = 32'h2;
    tick();
    idle();
    #1;
    chk("coll busy", busyMask0, 32'h80);
    tick();
    chk("coll wr1 reg", 32'(writeReg0), 32'd7);
    chk("coll wr1 data", writeData0, 32'h2);
    tick();
    chk("coll wr2 en", 32'(regWrite0), 32'd1);
    chk("coll wr2 data", writeData0, 32'h1);
    tick();
    chk("coll done", 32'(regWrite0), 32'd0);

    // fixed priority, continuous streams
    for (int i = 0; i < 10; i++) begin
      aluValid = 1'b1; aluRd = 5'd9; aluData = 32'h55;
      memValid = 1'b1; memRd = 5'(16 + (i % 8));
      memData = 32'h100 + 32'(i);
      #1;
      if (i >= 1) begin
        chk("fix aluReady", 32'(aluReady1), 32'd0);
        chk("fix memReady", 32'(memReady1), 32'd1);
      end
      tick();
      if (i >= 1) begin
        chk("fix wr en", 32'(regWrite1), 32'd1);
        chk("fix wr reg", 32'(writeReg1), 32'(16 + ((i - 1) % 8)));
        chk("fix wr data", writeData1, 32'h100 + 32'(i - 1));
      end
    end

    // reset mid-flight: both entries pending
    idle();
    reset = 1'b0;
    #1;
    chk("midrst busy", busyMask1, 32'd0);
    chk("midrst aluReady", 32'(aluReady1), 32'd0);
    tick();
    chk("midrst regWrite", 32'(regWrite1), 32'd0);
    chk("midrst regWrite0", 32'(regWrite0), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst no wr1", 32'(regWrite1), 32'd0);
      chk("midrst no wr0", 32'(regWrite0), 32'd0);
      chk("midrst busy after", busyMask1, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
